// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_ZERO_BYPASS_EN to route divide-by-zero straight to FIX (two-cycle latency).
module div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            BusyE,
    output logic            DoneM,
    output logic [XLEN-1:0] ResultM
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic            sel_rem_q, sel_rem_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            is_signed;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            unused_funct3;

    assign unused_funct3 = Funct3E[2];

    assign is_signed = ~Funct3E[0];
    assign a_abs = (is_signed && ForwardedSrcAE[XLEN-1]) ? -ForwardedSrcAE : ForwardedSrcAE;
    assign b_abs = (is_signed && ForwardedSrcBE[XLEN-1]) ? -ForwardedSrcBE : ForwardedSrcBE;

    // Partial remainder keeps its top bit so large unsigned divisors still compare correctly.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

    always_comb begin
        state_d   = state_q;
        sel_rem_d = sel_rem_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        result_d  = result_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (StartE && !FlushE) begin
                    sel_rem_d = Funct3E[1];
                    negq_d    = is_signed & (ForwardedSrcAE[XLEN-1] ^ ForwardedSrcBE[XLEN-1])
                                & (ForwardedSrcBE != '0);
                    negr_d    = is_signed & ForwardedSrcAE[XLEN-1];
                    quo_d     = a_abs;
                    dvs_d     = b_abs;
                    rem_d     = '0;
                    cnt_d     = CW'(XLEN - 1);
                    state_d   = StIter;
`ifdef DIV_ZERO_BYPASS_EN
                    if (ForwardedSrcBE == '0) begin
                        quo_d   = '1;
                        rem_d   = ForwardedSrcAE;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        state_d = StFix;
                    end
`endif
                end
            end
            StIter: begin
                if (!trial[XLEN+1]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFix: begin
                result_d = sel_rem_q ? (negr_q ? -rem_q : rem_q) : (negq_q ? -quo_q : quo_q);
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        // Flush abandons the operation without touching the held result.
        if (FlushE) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sel_rem_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_rem_q <= sel_rem_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    assign BusyE   = (state_q == StIter) || (state_q == StFix);
    assign DoneM   = (state_q == StDone);
    assign ResultM = result_q;

endmodule
